// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
// Shared definitions for the synchronous FWFT FIFO slice.
//   - default DATA_WIDTH, ADDR_WIDTH and threshold values
//   - count_width(): width of an occupancy count able to hold 0..2**addr_width
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 16;
    localparam int DEFAULT_ADDR_WIDTH   = 10;
    localparam int DEFAULT_AEMPTY_LEVEL = 4;
    // almost_full default sits this many entries below DEPTH
    localparam int DEFAULT_AFULL_MARGIN = 4;

    // A count of 0..DEPTH needs one bit more than the address.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_sdp_ram.sv
// sync_fifo_sdp_ram
// Simple dual-port RAM: one write port, one synchronous read port with read
// enable. rdata holds its last value while re is low, which lets the FIFO
// stall the prefetch stage without extra storage. Written to infer block RAM.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable (rdata updates on the next rising edge)
//   raddr  in  read address
//   rdata  out registered read data
module sync_fifo_sdp_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array has no reset; a reset port on the storage would stop
    // block-RAM inference, and the FIFO never reads an entry it has not written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Data path: RAM -> RAM read register (stage 1) -> output register (stage 2).
// count includes the words sitting in both stages. Threshold flags and
// s_ready are registered from the next count so they move with count.
// Optional feature: define SYNC_FIFO_WATERMARK_EN to build the max_count
// high-watermark register; otherwise max_count is tied to zero.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   clear              synchronous flush (wins over transfers on that edge)
//   s_valid/s_ready    write handshake, s_data write word
//   m_valid/m_ready    read handshake, m_data head-of-queue word
//   count              entries held, 0..DEPTH
//   almost_full        count >= AFULL_LEVEL
//   almost_empty       count <= AEMPTY_LEVEL
//   max_count          high-watermark of count (0 when feature disabled)
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
    parameter int AFULL_LEVEL  = (2**ADDR_WIDTH) - DEFAULT_AFULL_MARGIN,
    parameter int AEMPTY_LEVEL = DEFAULT_AEMPTY_LEVEL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   max_count
);

    localparam int CW = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(2**ADDR_WIDTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

    // Pointers carry one wrap bit so a RAM holding DEPTH words differs from empty.
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic                  rd_valid;   // stage 1 (RAM rdata) holds a word
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [CW-1:0]         count_next;

    logic wr_acc;
    logic rd_acc;
    logic load_out;
    logic ram_re;

    assign wr_acc   = s_valid && s_ready;
    assign rd_acc   = m_valid && m_ready;
    // Stage 2 takes stage 1 whenever it is empty or being emptied this edge.
    assign load_out = rd_valid && (!m_valid || m_ready);
    // Fetch from RAM when it holds unfetched words and stage 1 will be free.
    // Only words written on earlier edges are visible, so no read/write collision.
    assign ram_re   = !clear && (wr_ptr != rd_ptr) && (!rd_valid || load_out);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else begin
            count_next = count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    sync_fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc && !clear),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (s_data),
        .re    (ram_re),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_valid     <= 1'b0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            count        <= '0;
            s_ready      <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                rd_valid <= 1'b0;
                m_valid  <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
                end
                if (ram_re) begin
                    rd_ptr   <= rd_ptr + (ADDR_WIDTH+1)'(1);
                    rd_valid <= 1'b1;
                end else if (load_out) begin
                    rd_valid <= 1'b0;
                end
                if (load_out) begin
                    m_valid <= 1'b1;
                    m_data  <= ram_rdata;
                end else if (rd_acc) begin
                    m_valid <= 1'b0;
                end
            end
            count        <= count_next;
            s_ready      <= (count_next != DEPTH_C);
            almost_full  <= (count_next >= AFULL_C);
            almost_empty <= (count_next <= AEMPTY_C);
        end
    end

`ifdef SYNC_FIFO_WATERMARK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_count <= '0;
        end else if (clear) begin
            max_count <= '0;
        end else if (count_next > max_count) begin
            max_count <= count_next;
        end
    end
`else
    assign max_count = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft
// Directed bench for sync_fifo_fwft built with DEPTH = 8, AFULL_LEVEL = 4,
// AEMPTY_LEVEL = 4. A queue scoreboard supplies expected data and count.
module tb_sync_fifo_fwft;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 8;
`ifdef SYNC_FIFO_WATERMARK_EN
    localparam bit WM = 1'b1;
`else
    localparam bit WM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [AW:0]   count;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   max_count;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];
    int            exp_max = 0;

    sync_fifo_fwft #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .AFULL_LEVEL  (4),
        .AEMPTY_LEVEL (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .max_count    (max_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One clock: drive inputs, note which handshakes fire, advance the model.
    task automatic step(input logic sv, input logic [DW-1:0] sd, input logic mr,
                        output logic wf, output logic rf,
                        output logic [DW-1:0] got, output logic [DW-1:0] exp);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        wf  = sv && s_ready;
        rf  = mr && m_valid;
        got = m_data;
        exp = '0;
        @(posedge clk);
        #1;
        if (rf && model_q.size() > 0) exp = model_q.pop_front();
        if (wf) model_q.push_back(sd);
        if (model_q.size() > exp_max) exp_max = model_q.size();
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h0055;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        clear   = 1'b0;
        s_valid = 1'b0;
        model_q.delete();
        exp_max = 0;
    endtask

    task automatic test_reset();
        #23;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 16'h0) begin failures++; $display("FAIL rst_m_data got=%h exp=0000", m_data); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL rst_afull got=%b exp=0", almost_full); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL rst_aempty got=%b exp=1", almost_empty); end
        checks++; if (max_count !== 4'd0) begin failures++; $display("FAIL rst_max got=%0d exp=0", max_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fall_through();
        logic wf, rf;
        logic [DW-1:0] got, exp;
        step(1'b1, 16'h0001, 1'b0, wf, rf, got, exp);   // edge k
        s_valid = 1'b0;
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL ft_count got=%0d exp=1", count); end
        checks++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL ft_aempty got=%b exp=1", almost_empty); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL ft_mvalid_k got=%b exp=0", m_valid); end
        idle(1);                                          // edge k+1
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL ft_mvalid_k1 got=%b exp=0", m_valid); end
        idle(1);                                          // edge k+2
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL ft_mvalid_k2 got=%b exp=1", m_valid); end
        checks++; if (m_data !== 16'h0001) begin failures++; $display("FAIL ft_mdata got=%h exp=0001", m_data); end
        step(1'b0, 16'h0, 1'b1, wf, rf, got, exp);
        m_ready = 1'b0;
        checks++; if (count !== 4'd0 || m_valid !== 1'b0) begin failures++; $display("FAIL ft_drain count=%0d m_valid=%b exp=0/0", count, m_valid); end
    endtask

    task automatic test_fill();
        logic wf, rf;
        logic [DW-1:0] got, exp;
        int n;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0010 + DW'(i), 1'b0, wf, rf, got, exp);
        s_valid = 1'b0;
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
        checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill_afull got=%b exp=1", almost_full); end
        checks++; if (almost_empty !== 1'b0) begin failures++; $display("FAIL fill_aempty got=%b exp=0", almost_empty); end
        idle(2);
        step(1'b1, 16'hDEAD, 1'b0, wf, rf, got, exp);
        s_valid = 1'b0;
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_9th_count got=%0d exp=8", count); end
        n = 0;
        while (model_q.size() > 0 && n < 40) begin
            step(1'b0, 16'h0, 1'b1, wf, rf, got, exp);
            if (rf) begin
                checks++; if (got !== exp) begin failures++; $display("FAIL fill_order got=%h exp=%h", got, exp); end
            end
            n++;
        end
        m_ready = 1'b0;
        checks++; if (model_q.size() != 0) begin failures++; $display("FAIL fill_drain_timeout left=%0d exp=0", model_q.size()); end
        checks++; if (count !== 4'd0 || almost_empty !== 1'b1) begin failures++; $display("FAIL fill_end count=%0d aempty=%b exp=0/1", count, almost_empty); end
    endtask

    task automatic test_full_stream();
        logic wf, rf;
        logic [DW-1:0] got, exp, next;
        int n;
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0100 + DW'(i), 1'b0, wf, rf, got, exp);
        idle(3);
        next = 16'h0200;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL fs_first_s_ready got=%b exp=0", s_ready); end
        for (int c = 0; c < 20; c++) begin
            step(1'b1, next, 1'b1, wf, rf, got, exp);
            if (wf) next = next + 16'h1;
            checks++; if (!rf || got !== exp) begin failures++; $display("FAIL fs_read cyc=%0d fired=%b got=%h exp=%h", c, rf, got, exp); end
            checks++; if (count !== 4'(model_q.size()) || count < 4'd7) begin failures++; $display("FAIL fs_count cyc=%0d got=%0d exp=%0d", c, count, model_q.size()); end
            checks++; if (s_ready !== (model_q.size() != DEPTH)) begin failures++; $display("FAIL fs_s_ready cyc=%0d got=%b exp=%b", c, s_ready, model_q.size() != DEPTH); end
        end
        checks++; if (next !== 16'h0213) begin failures++; $display("FAIL fs_writes got=%h exp=0213", next); end
        n = 0;
        while (model_q.size() > 0 && n < 40) begin
            step(1'b0, 16'h0, 1'b1, wf, rf, got, exp);
            if (rf) begin
                checks++; if (got !== exp) begin failures++; $display("FAIL fs_drain got=%h exp=%h", got, exp); end
            end
            n++;
        end
        m_ready = 1'b0;
        checks++; if (model_q.size() != 0 || count !== 4'd0) begin failures++; $display("FAIL fs_end left=%0d count=%0d exp=0", model_q.size(), count); end
    endtask

    task automatic test_steady_stream();
        logic wf, rf;
        logic [DW-1:0] got, exp, head;
        int n;
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0300 + DW'(i), 1'b0, wf, rf, got, exp);
        idle(3);
        for (int c = 0; c < 10; c++) begin
            checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL ss_mvalid cyc=%0d got=%b exp=1", c, m_valid); end
            step(1'b1, 16'h0400 + DW'(c), 1'b1, wf, rf, got, exp);
            checks++; if (!rf || got !== exp) begin failures++; $display("FAIL ss_read cyc=%0d fired=%b got=%h exp=%h", c, rf, got, exp); end
        end
        head = model_q[0];
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 16'h0, 1'b0, wf, rf, got, exp);
            checks++; if (m_valid !== 1'b1 || m_data !== head) begin failures++; $display("FAIL ss_hold cyc=%0d m_valid=%b got=%h exp=%h", c, m_valid, m_data, head); end
        end
        n = 0;
        while (model_q.size() > 0 && n < 40) begin
            step(1'b0, 16'h0, 1'b1, wf, rf, got, exp);
            if (rf) begin
                checks++; if (got !== exp) begin failures++; $display("FAIL ss_drain got=%h exp=%h", got, exp); end
            end
            n++;
        end
        m_ready = 1'b0;
        checks++; if (model_q.size() != 0) begin failures++; $display("FAIL ss_drain_timeout left=%0d exp=0", model_q.size()); end
    endtask

    task automatic test_watermark();
        logic wf, rf;
        logic [DW-1:0] got, exp;
        int n;
        do_clear();
        for (int i = 0; i < 6; i++) step(1'b1, 16'h0500 + DW'(i), 1'b0, wf, rf, got, exp);
        s_valid = 1'b0;
        checks++; if (count !== 4'd6) begin failures++; $display("FAIL wm_count got=%0d exp=6", count); end
        checks++; if (max_count !== (WM ? 4'(exp_max) : 4'd0)) begin failures++; $display("FAIL wm_peak got=%0d exp=%0d", max_count, WM ? exp_max : 0); end
        idle(3);
        n = 0;
        while (model_q.size() > 0 && n < 40) begin
            step(1'b0, 16'h0, 1'b1, wf, rf, got, exp);
            n++;
        end
        step(1'b1, 16'h0600, 1'b0, wf, rf, got, exp);
        step(1'b1, 16'h0601, 1'b0, wf, rf, got, exp);
        s_valid = 1'b0;
        checks++; if (max_count !== (WM ? 4'd6 : 4'd0)) begin failures++; $display("FAIL wm_hold got=%0d exp=%0d", max_count, WM ? 6 : 0); end
        do_clear();
        checks++; if (max_count !== 4'd0) begin failures++; $display("FAIL wm_clear got=%0d exp=0", max_count); end
    endtask

    task automatic test_clear();
        logic wf, rf;
        logic [DW-1:0] got, exp;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0700 + DW'(i), 1'b0, wf, rf, got, exp);
        do_clear();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", count); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL clr_mvalid got=%b exp=0", m_valid); end
        checks++; if (max_count !== 4'd0) begin failures++; $display("FAIL clr_max got=%0d exp=0", max_count); end
        checks++; if (s_ready !== 1'b1 || almost_empty !== 1'b1 || almost_full !== 1'b0) begin failures++; $display("FAIL clr_flags s_ready=%b aempty=%b afull=%b exp=1/1/0", s_ready, almost_empty, almost_full); end
        idle(3);
        checks++; if (m_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL clr_dropped m_valid=%b count=%0d exp=0/0", m_valid, count); end
        step(1'b1, 16'h0077, 1'b0, wf, rf, got, exp);
        idle(2);
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0077) begin failures++; $display("FAIL clr_restart m_valid=%b got=%h exp=0077", m_valid, m_data); end
        step(1'b0, 16'h0, 1'b1, wf, rf, got, exp);
        m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic wf, rf;
        logic [DW-1:0] got, exp;
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0800 + DW'(i), 1'b0, wf, rf, got, exp);
        // Still mid-burst: s_valid high, m_ready high.
        s_valid = 1'b1;
        s_data  = 16'h0900;
        m_ready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 16'h0) begin failures++; $display("FAIL arst_hs s_ready=%b m_valid=%b m_data=%h exp=1/0/0000", s_ready, m_valid, m_data); end
        checks++; if (count !== 4'd0 || max_count !== 4'd0) begin failures++; $display("FAIL arst_count count=%0d max=%0d exp=0/0", count, max_count); end
        checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin failures++; $display("FAIL arst_flags afull=%b aempty=%b exp=0/1", almost_full, almost_empty); end
        s_valid = 1'b0;
        m_ready = 1'b0;
        model_q.delete();
        exp_max = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 16'hABCD, 1'b0, wf, rf, got, exp);
        s_valid = 1'b0;
        idle(2);
        checks++; if (m_valid !== 1'b1 || m_data !== 16'hABCD || count !== 4'd1) begin failures++; $display("FAIL arst_first m_valid=%b got=%h count=%0d exp=1/abcd/1", m_valid, m_data, count); end
    endtask

    initial begin
        test_reset();
        test_fall_through();
        test_fill();
        test_full_stream();
        test_steady_stream();
        test_watermark();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
